// File: rtl/mux8_word_serializer_pkg.sv
// Shared definitions for the mux8 word serializer.
//   state_e  : FSM encoding (StIdle = 1'b0, StShift = 1'b1)
//   LAST_SEL : final counter position of a word
//   sel_of() : maps the bit counter to the mux select for a given bit order
package mux8_word_serializer_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    localparam logic [2:0] LAST_SEL = 3'd7;

    // LSB-first walks the select upward with the counter; MSB-first mirrors it.
    function automatic logic [2:0] sel_of(input logic [2:0] cnt, input bit msb_first);
        return msb_first ? (LAST_SEL - cnt) : cnt;
    endfunction

endpackage

// File: rtl/mux8_word_serializer_mux8_sel.sv
// Purely combinational 8:1 bit multiplexer.
//   hold [7:0] : data word
//   sel  [2:0] : select {s2,s1,s0}
//   y          : hold[sel]
module mux8_sel (
    input  logic [7:0] hold,
    input  logic [2:0] sel,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        unique case (sel)
            3'd0: y = hold[0];
            3'd1: y = hold[1];
            3'd2: y = hold[2];
            3'd3: y = hold[3];
            3'd4: y = hold[4];
            3'd5: y = hold[5];
            3'd6: y = hold[6];
            3'd7: y = hold[7];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux8_word_serializer.sv
// Parallel-to-serial front end: accepts an 8-bit word over valid/ready, holds it, and sweeps
// a 3-bit select through an 8:1 mux so one bit per clock leaves on ser_out.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   din, load_valid     : parallel word and its valid
//   load_ready          : word can be accepted this cycle
//   stall               : consumer back-pressure, freezes the sweep
//   sel                 : current mux select
//   ser_out, ser_valid  : serial bit and its valid
//   frame_start/end     : first / last bit of a word
//   busy                : a word is in flight
module mux8_word_serializer
    import mux8_word_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic       stall,
    output logic [2:0] sel,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d;
    logic       accept;
    logic       mux_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Ready either when idle or on the last unstalled bit, which lets words stream gap-free.
    always_comb begin
        load_ready = (state_q == StIdle) ||
                     ((state_q == StShift) && (cnt_q == LAST_SEL) && !stall);
        accept     = load_valid && load_ready;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    hold_d  = din;
                    cnt_d   = 3'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!stall) begin
                    if (cnt_q == LAST_SEL) begin
                        if (accept) begin
                            hold_d = din;
                            cnt_d  = 3'd0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel = sel_of(cnt_q, MSB_FIRST);
    end

    mux8_sel u_mux8_sel (
        .hold (hold_q),
        .sel  (sel),
        .y    (mux_y)
    );

    always_comb begin
        busy        = (state_q == StShift);
        ser_out     = busy && mux_y;
        ser_valid   = busy && !stall;
        frame_start = ser_valid && (cnt_q == 3'd0);
        frame_end   = ser_valid && (cnt_q == LAST_SEL);
    end

endmodule

// File: tb/tb_mux8_word_serializer.sv
// Self-checking bench: two instances (LSB-first and MSB-first) share stimulus; a word-level
// model is compared every cycle, and literal bit sequences pin the model.
module tb_mux8_word_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'd0;
    logic       load_valid = 1'b0;
    logic       stall = 1'b0;

    logic       load_ready0, ser_out0, ser_valid0, frame_start0, frame_end0, busy0;
    logic       load_ready1, ser_out1, ser_valid1, frame_start1, frame_end1, busy1;
    logic [2:0] sel0, sel1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mux8_word_serializer #(.MSB_FIRST(1'b0)) u_dut_lsb (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .load_valid  (load_valid),
        .load_ready  (load_ready0),
        .stall       (stall),
        .sel         (sel0),
        .ser_out     (ser_out0),
        .ser_valid   (ser_valid0),
        .frame_start (frame_start0),
        .frame_end   (frame_end0),
        .busy        (busy0)
    );

    mux8_word_serializer #(.MSB_FIRST(1'b1)) u_dut_msb (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .load_valid  (load_valid),
        .load_ready  (load_ready1),
        .stall       (stall),
        .sel         (sel1),
        .ser_out     (ser_out1),
        .ser_valid   (ser_valid1),
        .frame_start (frame_start1),
        .frame_end   (frame_end1),
        .busy        (busy1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-level model: the word being sent, how far into it we are, whether one is in flight.
    logic [7:0] m_word = 8'd0;
    int         m_pos = 0;
    bit         m_active = 1'b0;

    function automatic bit m_ready();
        return !m_active || (m_pos == 7 && !stall);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_word   <= 8'd0;
            m_pos    <= 0;
            m_active <= 1'b0;
        end else if (load_valid && m_ready()) begin
            m_word   <= din;
            m_pos    <= 0;
            m_active <= 1'b1;
        end else if (m_active && !stall) begin
            if (m_pos == 7) m_active <= 1'b0;
            else m_pos <= m_pos + 1;
        end
    end

    // Per-cycle comparison plus capture of the emitted serial streams.
    bit q0[$];
    bit q1[$];
    int idx0[$];

    always @(negedge clk) begin
        bit e_valid;
        bit e_bit0, e_bit1;
        cyc++;
        e_valid = m_active && !stall;
        e_bit0  = m_active ? m_word[m_pos] : 1'b0;
        e_bit1  = m_active ? m_word[7 - m_pos] : 1'b0;
        check("lsb.load_ready", 16'(load_ready0), 16'(m_ready()));
        check("lsb.sel", 16'(sel0), 16'(m_pos));
        check("lsb.ser_out", 16'(ser_out0), 16'(e_bit0));
        check("lsb.ser_valid", 16'(ser_valid0), 16'(e_valid));
        check("lsb.frame_start", 16'(frame_start0), 16'(e_valid && m_pos == 0));
        check("lsb.frame_end", 16'(frame_end0), 16'(e_valid && m_pos == 7));
        check("lsb.busy", 16'(busy0), 16'(m_active));
        check("msb.load_ready", 16'(load_ready1), 16'(m_ready()));
        check("msb.sel", 16'(sel1), 16'(7 - m_pos));
        check("msb.ser_out", 16'(ser_out1), 16'(e_bit1));
        check("msb.ser_valid", 16'(ser_valid1), 16'(e_valid));
        check("msb.frame_start", 16'(frame_start1), 16'(e_valid && m_pos == 0));
        check("msb.frame_end", 16'(frame_end1), 16'(e_valid && m_pos == 7));
        check("msb.busy", 16'(busy1), 16'(m_active));
        if (ser_valid0) begin
            q0.push_back(ser_out0);
            idx0.push_back(cyc);
        end
        if (ser_valid1) q1.push_back(ser_out1);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a word and hold it until accepted; returns one step after the accepting edge.
    task automatic send(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        din = w;
        load_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (load_ready0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        tick(1);
        load_valid = 1'b0;
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: word %0h never accepted", w);
        end
    endtask

    // First-sent bit ends up most significant.
    function automatic logic [15:0] pack(input bit q[$]);
        logic [15:0] v;
        v = 16'd0;
        foreach (q[i]) v = {v[14:0], q[i]};
        return v;
    endfunction

    task automatic clear_streams();
        q0.delete();
        q1.delete();
        idx0.delete();
    endtask

    initial begin
        // Reset, then a mid-idle reset pulse.
        tick(3);
        rst = 1'b0;
        tick(2);
        #2 rst = 1'b1;
        tick(1);
        rst = 1'b0;
        #1;
        check("reset.load_ready", 16'(load_ready0), 16'd1);
        check("reset.busy", 16'(busy0), 16'd0);
        check("reset.ser_valid", 16'(ser_valid0), 16'd0);
        check("reset.sel_lsb", 16'(sel0), 16'd0);
        check("reset.sel_msb", 16'(sel1), 16'd7);
        check("reset.ser_out", 16'(ser_out1), 16'd0);
        tick(1);

        // Single word.
        clear_streams();
        send(8'b1010_0110);
        tick(10);
        check("single.len", 16'(q0.size()), 16'd8);
        check("single.lsb_bits", pack(q0), 16'h0065);
        check("single.msb_bits", pack(q1), 16'h00A6);
        check("single.busy_after", 16'(busy0), 16'd0);

        // Back-to-back words.
        clear_streams();
        send(8'hFF);
        send(8'h00);
        tick(10);
        check("b2b.len", 16'(q0.size()), 16'd16);
        check("b2b.bits", pack(q0), 16'hFF00);
        if (idx0.size() == 16) check("b2b.contiguous", 16'(idx0[15] - idx0[0]), 16'd15);

        // Stall at cnt=3 with a load_valid pulse during the stall.
        clear_streams();
        send(8'h0F);
        tick(3);
        stall = 1'b1;
        din = 8'hAA;
        load_valid = 1'b1;
        #1;
        check("stall.load_ready", 16'(load_ready0), 16'd0);
        check("stall.sel_hold", 16'(sel0), 16'd3);
        tick(3);
        stall = 1'b0;
        load_valid = 1'b0;
        tick(12);
        check("stall.len", 16'(q0.size()), 16'd8);
        check("stall.bits", pack(q0), 16'h00F0);
        if (idx0.size() == 8) check("stall.span", 16'(idx0[7] - idx0[0]), 16'd10);

        // Reset mid-word at cnt=4, observed before any clock edge.
        clear_streams();
        send(8'h5A);
        tick(4);
        #2 rst = 1'b1;
        #1;
        check("midrst.busy", 16'(busy0), 16'd0);
        check("midrst.ser_valid", 16'(ser_valid0), 16'd0);
        check("midrst.sel_lsb", 16'(sel0), 16'd0);
        check("midrst.sel_msb", 16'(sel1), 16'd7);
        check("midrst.partial_len", 16'(q0.size()), 16'd4);
        tick(2);
        rst = 1'b0;
        tick(1);
        clear_streams();
        send(8'hC3);
        tick(10);
        check("midrst.new_bits", pack(q0), 16'h00C3);
        check("midrst.new_len", 16'(q0.size()), 16'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
